// File: rtl/pulse_train_gen.sv
// Burst pulse generator: on an accepted start, drives q with n_pulses rectangular
// pulses of HIGH_LEN high / LOW_LEN low cycles, with busy/done handshake.
module pulse_train_gen #(
    parameter int HIGH_LEN = 4,
    parameter int LOW_LEN  = 4,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] n_pulses,
    output logic             q,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pulse_cnt
);

    localparam int MAX_LEN = (HIGH_LEN > LOW_LEN) ? HIGH_LEN : LOW_LEN;
    localparam int PH_W    = $clog2(MAX_LEN) + 1;
    localparam logic [PH_W-1:0] HIGH_LAST = PH_W'(HIGH_LEN - 1);
    localparam logic [PH_W-1:0] LOW_LAST  = PH_W'(LOW_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HIGH,
        S_LOW
    } state_t;

    state_t           state_reg;
    logic [PH_W-1:0]  phase_reg;
    logic [CNT_W-1:0] target_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             q_reg;
    logic             busy_reg;
    logic             done_reg;
    logic [CNT_W-1:0] cnt_inc;

    assign cnt_inc   = cnt_reg + CNT_W'(1);
    assign q         = q_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign pulse_cnt = cnt_reg;

    // phase_reg counts down the remaining cycles of the current HIGH/LOW phase
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg  <= S_IDLE;
            phase_reg  <= '0;
            target_reg <= '0;
            cnt_reg    <= '0;
            q_reg      <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start && !stop && (n_pulses != '0)) begin
                        state_reg  <= S_HIGH;
                        phase_reg  <= HIGH_LAST;
                        target_reg <= n_pulses;
                        cnt_reg    <= '0;
                        q_reg      <= 1'b1;
                        busy_reg   <= 1'b1;
                    end
                end
                S_HIGH: begin
                    if (stop) begin
                        state_reg <= S_IDLE;
                        q_reg     <= 1'b0;
                        busy_reg  <= 1'b0;
                    end else if (phase_reg == '0) begin
                        state_reg <= S_LOW;
                        phase_reg <= LOW_LAST;
                        q_reg     <= 1'b0;
                    end else begin
                        phase_reg <= phase_reg - PH_W'(1);
                    end
                end
                S_LOW: begin
                    if (stop) begin
                        state_reg <= S_IDLE;
                        q_reg     <= 1'b0;
                        busy_reg  <= 1'b0;
                    end else if (phase_reg == '0) begin
                        cnt_reg <= cnt_inc;
                        if (cnt_inc == target_reg) begin
                            state_reg <= S_IDLE;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg <= S_HIGH;
                            phase_reg <= HIGH_LAST;
                            q_reg     <= 1'b1;
                        end
                    end else begin
                        phase_reg <= phase_reg - PH_W'(1);
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                    q_reg     <= 1'b0;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_train_gen.sv
// Bench for pulse_train_gen: two instances (4/4 and 1/1) share randomized and directed
// stimulus; a timing-formula model predicts outputs, a scoreboard matches done strobes.
module tb_pulse_train_gen;

    localparam int CNT_W = 8;
    localparam int H0 = 4;
    localparam int L0 = 4;
    localparam int H1 = 1;
    localparam int L1 = 1;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic                  start = 1'b0;
    logic                  stop = 1'b0;
    logic [CNT_W-1:0]      n_pulses = '0;
    logic [1:0]            q_v;
    logic [1:0]            busy_v;
    logic [1:0]            done_v;
    logic [1:0][CNT_W-1:0] pcnt_v;

    int          tests = 0;
    int          fails = 0;
    int unsigned cyc = 0;

    pulse_train_gen #(.HIGH_LEN(H0), .LOW_LEN(L0), .CNT_W(CNT_W)) dut0 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .n_pulses(n_pulses),
        .q(q_v[0]), .busy(busy_v[0]), .done(done_v[0]), .pulse_cnt(pcnt_v[0])
    );

    pulse_train_gen #(.HIGH_LEN(H1), .LOW_LEN(L1), .CNT_W(CNT_W)) dut1 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .n_pulses(n_pulses),
        .q(q_v[1]), .busy(busy_v[1]), .done(done_v[1]), .pulse_cnt(pcnt_v[1])
    );

    always #5 clk = ~clk;

    function automatic int unsigned hl(int i);
        return (i == 0) ? H0 : H1;
    endfunction

    function automatic int unsigned per(int i);
        return (i == 0) ? (H0 + L0) : (H1 + L1);
    endfunction

    // Reference model: a burst is just (start edge, count); outputs follow from arithmetic
    bit          m_active[2];
    int unsigned m_e0[2];
    int unsigned m_n[2];
    int unsigned m_cnt[2];
    bit          m_done[2];

    typedef struct packed {
        int unsigned n;
        int unsigned done_at;
    } exp_t;
    exp_t sb_q[2][$];

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_active[i] = 1'b0;
            m_e0[i] = 0;
            m_n[i] = 0;
            m_cnt[i] = 0;
            m_done[i] = 1'b0;
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 2; i++) begin
            automatic int unsigned c = cyc + 1;
            automatic int unsigned k = c - m_e0[i];
            automatic int unsigned nn = n_pulses;
            if (!rst) begin
                if (m_active[i]) void'(sb_q[i].pop_back());
                m_active[i] <= 1'b0;
                m_cnt[i] <= 0;
                m_done[i] <= 1'b0;
            end else begin
                m_done[i] <= 1'b0;
                if (m_active[i]) begin
                    if (stop) begin
                        m_active[i] <= 1'b0;
                        m_cnt[i] <= (k - 1) / per(i);
                        void'(sb_q[i].pop_back());
                    end else if (k == m_n[i] * per(i)) begin
                        m_active[i] <= 1'b0;
                        m_cnt[i] <= m_n[i];
                        m_done[i] <= 1'b1;
                    end
                end else if (start && !stop && (nn != 0)) begin
                    m_active[i] <= 1'b1;
                    m_e0[i] <= c;
                    m_n[i] <= nn;
                    m_cnt[i] <= 0;
                    sb_q[i].push_back('{n: nn, done_at: c + nn * per(i)});
                end
            end
        end
    end

    task automatic check(string name, int i, int unsigned act, int unsigned exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s[dut%0d] cycle %0d: got %0d, expected %0d", name, i, cyc, act, exp);
        end
    endtask

    // Monitor: per-cycle output check plus done-strobe scoreboard
    always @(negedge clk) begin
        if (cyc >= 1) begin
            for (int i = 0; i < 2; i++) begin
                automatic int unsigned eq, eb, ed, ec, k;
                if (m_active[i]) begin
                    k  = cyc - m_e0[i];
                    eq = ((k % per(i)) < hl(i)) ? 1 : 0;
                    eb = 1;
                    ed = 0;
                    ec = k / per(i);
                end else begin
                    eq = 0;
                    eb = 0;
                    ed = m_done[i] ? 1 : 0;
                    ec = m_cnt[i];
                end
                check("q", i, 32'(q_v[i]), eq);
                check("busy", i, 32'(busy_v[i]), eb);
                check("done", i, 32'(done_v[i]), ed);
                check("pulse_cnt", i, 32'(pcnt_v[i]), ec);
                if (done_v[i]) begin
                    if (sb_q[i].size() == 0) begin
                        check("sb_unexpected_done", i, 1, 0);
                    end else begin
                        automatic exp_t e = sb_q[i].pop_front();
                        check("sb_done_cycle", i, cyc, e.done_at);
                        check("sb_final_cnt", i, 32'(pcnt_v[i]), e.n);
                    end
                end
            end
        end
    end

    task automatic tick(int nc);
        repeat (nc) @(negedge clk);
    endtask

    task automatic pulse_start(int n);
        start = 1'b1;
        n_pulses = CNT_W'(n);
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_idle(int bound);
        int n = 0;
        while ((busy_v != 2'b00) && (n < bound)) begin
            tick(1);
            n++;
        end
        if (busy_v != 2'b00) begin
            tests++;
            fails++;
            $display("FAIL wait_idle timeout at cycle %0d: busy=%b, required 00", cyc, busy_v);
        end
        tick(2);
    endtask

    initial begin
        int n;
        // Reset held two edges with start asserted
        rst = 1'b0;
        start = 1'b1;
        n_pulses = CNT_W'(3);
        tick(2);
        rst = 1'b1;
        start = 1'b0;
        tick(3);

        // Reference burst of two pulses
        pulse_start(2);
        wait_idle(100);

        // Zero-length request is ignored
        pulse_start(0);
        tick(5);

        // Restart attempts and n_pulses changes while busy are ignored
        pulse_start(3);
        tick(5);
        start = 1'b1;
        n_pulses = CNT_W'(5);
        tick(1);
        start = 1'b0;
        tick(7);
        pulse_start(5);
        wait_idle(100);

        // Stop during second high phase of the 4/4 instance
        pulse_start(4);
        tick(9);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        wait_idle(100);

        // start and stop together in IDLE
        start = 1'b1;
        stop = 1'b1;
        n_pulses = CNT_W'(2);
        tick(1);
        start = 1'b0;
        stop = 1'b0;
        tick(3);

        // Reset mid-burst
        pulse_start(4);
        tick(5);
        rst = 1'b0;
        tick(1);
        rst = 1'b1;
        tick(3);

        // Restart in the done cycle
        pulse_start(1);
        n = 0;
        while (!done_v[0] && (n < 50)) begin
            tick(1);
            n++;
        end
        if (!done_v[0]) begin
            tests++;
            fails++;
            $display("FAIL wait_done timeout at cycle %0d: done=0, required 1", cyc);
        end
        start = 1'b1;
        n_pulses = CNT_W'(1);
        tick(1);
        start = 1'b0;
        wait_idle(100);

        // Full-scale count
        pulse_start(255);
        wait_idle(3000);

        // Randomized traffic
        repeat (1500) begin
            start = ($urandom_range(0, 3) == 0);
            stop = ($urandom_range(0, 39) == 0);
            rst = ($urandom_range(0, 299) != 0);
            n_pulses = CNT_W'($urandom_range(0, 6));
            tick(1);
        end
        start = 1'b0;
        stop = 1'b0;
        rst = 1'b1;
        wait_idle(200);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
